// File: rtl/obi_mem_init_pkg.sv
// Purpose: shared types and helpers for the OBI memory init/verify manager.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package obi_mem_init_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // The outstanding counter is sized for the largest supported depth
  // (2^IdWidth with IdWidth up to 4), so any legal MaxOutstanding fits.
  localparam int unsigned MaxOutstandingCap = 16;
  localparam int unsigned CntWidth          = $clog2(MaxOutstandingCap + 1);

  // One 32-bit lane of pattern word k; callers replicate it across the bus.
  function automatic logic [31:0] pattern_word(input logic [31:0] seed,
                                               input logic [31:0] k);
    pattern_word = seed + k;
  endfunction

endpackage

// File: rtl/obi_mem_init_verify.sv
// Purpose: in-order response counter, pattern compare and saturating mismatch counter.
// Latency: compare in the response cycle, mismatch_cnt_o updates on the next cycle.
// Backpressure: none; accepts one response per cycle unconditionally.
//
// Ports: clk_i/rst_i clock and async active-high reset; clear_i restarts the
// response index and mismatch count; check_en_i enables comparing (read-verify);
// rsp_valid_i qualifies rdata_i; seed_i is the command seed; mismatch_cnt_o result.
module obi_mem_init_verify
  import obi_mem_init_pkg::*;
#(
  parameter int unsigned DataWidth = 512,
  parameter int unsigned LenWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 check_en_i,
  input  logic                 rsp_valid_i,
  input  logic [DataWidth-1:0] rdata_i,
  input  logic [31:0]          seed_i,
  output logic [15:0]          mismatch_cnt_o
);

  logic [LenWidth-1:0]  rsp_cnt;
  logic [DataWidth-1:0] exp_word;
  logic                 mismatch;

  // Responses return in issue order, so the response index is the word index.
  assign exp_word = {(DataWidth/32){pattern_word(seed_i, 32'(rsp_cnt))}};
  assign mismatch = rsp_valid_i && check_en_i && (rdata_i != exp_word);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_cnt        <= '0;
      mismatch_cnt_o <= '0;
    end else if (clear_i) begin
      rsp_cnt        <= '0;
      mismatch_cnt_o <= '0;
    end else begin
      if (rsp_valid_i) begin
        rsp_cnt <= rsp_cnt + LenWidth'(1);
      end
      if (mismatch && (mismatch_cnt_o != 16'hFFFF)) begin
        mismatch_cnt_o <= mismatch_cnt_o + 16'd1;
      end
    end
  end

endmodule

// File: rtl/obi_mem_init_mgr.sv
// Purpose: OBI manager issuing write-fill / read-verify sweeps over a contiguous region.
// Latency: first request the cycle after command accept; done_o N+2 cycles after accept.
// Backpressure: request fields held until obi_gnt_i; issue pauses at MaxOutstanding.
//
// Ports: cmd_* command handshake (we, base address, word count, seed);
// obi_* OBI manager port (rready tied high, be all ones); busy_o command in
// progress; done_o completion pulse; err_o sticky response error; mismatch_cnt_o
// read-verify mismatch count (both cleared on the next command accept).
module obi_mem_init_mgr
  import obi_mem_init_pkg::*;
#(
  parameter int unsigned AddrWidth      = 48,
  parameter int unsigned DataWidth      = 512,
  parameter int unsigned IdWidth        = 2,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned LenWidth       = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic                   cmd_we_i,
  input  logic [AddrWidth-1:0]   cmd_addr_i,
  input  logic [LenWidth-1:0]    cmd_len_i,
  input  logic [31:0]            cmd_seed_i,
  output logic                   obi_req_o,
  input  logic                   obi_gnt_i,
  output logic [AddrWidth-1:0]   obi_addr_o,
  output logic                   obi_we_o,
  output logic [DataWidth/8-1:0] obi_be_o,
  output logic [DataWidth-1:0]   obi_wdata_o,
  output logic [IdWidth-1:0]     obi_aid_o,
  input  logic                   obi_rvalid_i,
  output logic                   obi_rready_o,
  input  logic [DataWidth-1:0]   obi_rdata_i,
  input  logic                   obi_err_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [15:0]            mismatch_cnt_o
);

  localparam logic [AddrWidth-1:0] WordBytes = AddrWidth'(DataWidth / 8);
  localparam logic [CntWidth-1:0]  OutMax    = CntWidth'(MaxOutstanding);

  state_e                state;
  logic                  we_q;
  logic [LenWidth-1:0]   len_q;
  logic [LenWidth-1:0]   issued;
  logic [LenWidth-1:0]   issued_nxt;
  logic [31:0]           seed_q;
  logic [AddrWidth-1:0]  addr_q;
  logic [CntWidth-1:0]   outstanding;
  logic [CntWidth-1:0]   out_nxt;
  logic                  accept;
  logic                  grant;
  logic                  rsp;

  assign cmd_ready_o = (state == ST_IDLE);
  assign busy_o      = (state != ST_IDLE);
  assign done_o      = (state == ST_DONE);
  assign accept      = cmd_valid_i && cmd_ready_o;

  // Request fields come straight from registers that only move on a grant,
  // so they stay stable while the subordinate stalls.
  assign obi_req_o    = (state == ST_ISSUE) && (issued != len_q) && (outstanding < OutMax);
  assign obi_addr_o   = addr_q;
  assign obi_we_o     = we_q;
  assign obi_be_o     = '1;
  assign obi_wdata_o  = {(DataWidth/32){pattern_word(seed_q, 32'(issued))}};
  assign obi_aid_o    = issued[IdWidth-1:0];
  assign obi_rready_o = 1'b1;

  assign grant = obi_req_o && obi_gnt_i;
  // A response with nothing outstanding is stale (e.g. from before a reset).
  assign rsp   = obi_rvalid_i && (outstanding != '0);

  assign issued_nxt = issued + LenWidth'(grant);

  always_comb begin
    out_nxt = outstanding;
    if (grant && !rsp) begin
      out_nxt = outstanding + CntWidth'(1);
    end else if (!grant && rsp) begin
      out_nxt = outstanding - CntWidth'(1);
    end
  end

  // Transitions look at next-cycle counter values so the final response
  // lands DONE on the following cycle without an extra DRAIN cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      we_q        <= 1'b0;
      len_q       <= '0;
      seed_q      <= '0;
      addr_q      <= '0;
      issued      <= '0;
      outstanding <= '0;
      err_o       <= 1'b0;
    end else begin
      issued      <= issued_nxt;
      outstanding <= out_nxt;
      if (grant) begin
        addr_q <= addr_q + WordBytes;
      end
      if (rsp && obi_err_i) begin
        err_o <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            we_q   <= cmd_we_i;
            len_q  <= cmd_len_i;
            seed_q <= cmd_seed_i;
            addr_q <= cmd_addr_i;
            issued <= '0;
            err_o  <= 1'b0;
            state  <= (cmd_len_i == '0) ? ST_DONE : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (issued_nxt == len_q) begin
            state <= (out_nxt == '0) ? ST_DONE : ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (out_nxt == '0) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  obi_mem_init_verify #(
    .DataWidth (DataWidth),
    .LenWidth  (LenWidth)
  ) u_verify (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .clear_i        (accept),
    .check_en_i     (!we_q),
    .rsp_valid_i    (rsp),
    .rdata_i        (obi_rdata_i),
    .seed_i         (seed_q),
    .mismatch_cnt_o (mismatch_cnt_o)
  );

endmodule

// File: tb/tb_obi_mem_init_mgr.sv
// Purpose: self-checking bench for obi_mem_init_mgr with a memory model and scoreboard.
// Latency: model responds in order, a configurable number of cycles after grant.
// Backpressure: model can drop grant for 3 cycles after a chosen grant index.
module tb_obi_mem_init_mgr;

  localparam int AW = 48;
  localparam int DW = 512;
  localparam int IW = 2;
  localparam int MO = 4;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [AW-1:0] cmd_addr_i;
  logic [LW-1:0] cmd_len_i;
  logic [31:0]   cmd_seed_i;
  logic          obi_req_o, obi_gnt_i, obi_we_o, obi_rvalid_i, obi_rready_o, obi_err_i;
  logic [AW-1:0] obi_addr_o;
  logic [DW/8-1:0] obi_be_o;
  logic [DW-1:0] obi_wdata_o, obi_rdata_i;
  logic [IW-1:0] obi_aid_o;
  logic          busy_o, done_o, err_o;
  logic [15:0]   mismatch_cnt_o;

  always #5 clk = ~clk;

  obi_mem_init_mgr #(
    .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .MaxOutstanding(MO), .LenWidth(LW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i), .cmd_seed_i(cmd_seed_i),
    .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o),
    .obi_we_o(obi_we_o), .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
    .obi_aid_o(obi_aid_o), .obi_rvalid_i(obi_rvalid_i), .obi_rready_o(obi_rready_o),
    .obi_rdata_i(obi_rdata_i), .obi_err_i(obi_err_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .mismatch_cnt_o(mismatch_cnt_o)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [IW-1:0] aid;
  } req_t;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
    logic          err;
  } rsp_t;

  req_t exp_q[$];
  rsp_t rsp_q[$];
  logic [DW-1:0] mem [logic [AW-1:0]];

  int checks = 0;
  int errors = 0;
  int cyc = 0, lat = 1, stall_idx = -1, stall_left = 0;
  int corrupt_idx = -1, err_idx = -1, grant_idx = 0, tb_out = 0, max_out = 0;
  bit stray = 1'b0;
  req_t held;
  bit held_vld = 1'b0;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_pat(input logic [31:0] seed, input int k);
    logic [DW-1:0] p;
    for (int i = 0; i < DW/32; i++) p[i*32 +: 32] = seed + 32'(k);
    return p;
  endfunction

  // Memory model: grants, in-order responses, optional corruption/error/stall.
  initial begin
    obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; obi_rdata_i = '0; obi_err_i = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst) begin
        rsp_q.delete();
        tb_out = 0;
        stall_left = 0;
        held_vld = 1'b0;
      end
      obi_gnt_i = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      obi_rvalid_i = 1'b0; obi_err_i = 1'b0; obi_rdata_i = '0;
      if (stray) begin
        obi_rvalid_i = 1'b1; obi_err_i = 1'b1; obi_rdata_i = {16{32'hDEADBEEF}};
        stray = 1'b0;
      end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        obi_rvalid_i = 1'b1;
        obi_rdata_i  = rsp_q[0].data;
        obi_err_i    = rsp_q[0].err;
        void'(rsp_q.pop_front());
        tb_out--;
      end
      @(negedge clk);
      if (!rst) begin
        if (obi_req_o && held_vld) begin
          check_val("stable_addr", obi_addr_o, held.addr);
          check_val("stable_wdata", obi_wdata_o, held.wdata);
          check_val("stable_aid", obi_aid_o, held.aid);
        end
        held_vld = 1'b0;
        if (obi_req_o && obi_gnt_i) begin
          req_t e;
          rsp_t r;
          tb_out++;
          if (tb_out > max_out) max_out = tb_out;
          if (exp_q.size() == 0) begin
            check_val("extra_req", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check_val("req_addr", obi_addr_o, e.addr);
            check_val("req_we", obi_we_o, e.we);
            check_val("req_aid", obi_aid_o, e.aid);
            if (e.we) check_val("req_wdata", obi_wdata_o, e.wdata);
          end
          if (obi_we_o) begin
            mem[obi_addr_o] = obi_wdata_o;
            r.data = '0;
          end else begin
            r.data = mem.exists(obi_addr_o) ? mem[obi_addr_o] : '0;
            if (grant_idx == corrupt_idx) r.data[0] = ~r.data[0];
          end
          r.due = cyc + lat;
          r.err = (grant_idx == err_idx);
          rsp_q.push_back(r);
          if (grant_idx == stall_idx) stall_left = 3;
          grant_idx++;
        end else if (obi_req_o) begin
          held.addr = obi_addr_o; held.wdata = obi_wdata_o; held.aid = obi_aid_o;
          held.we = obi_we_o;
          held_vld = 1'b1;
        end
      end
    end
  end

  task automatic push_exp(input logic we, input logic [AW-1:0] base, input int len, input logic [31:0] seed);
    for (int k = 0; k < len; k++) begin
      req_t e;
      e.addr = base + AW'(k * (DW/8));
      e.we = we;
      e.wdata = exp_pat(seed, k);
      e.aid = IW'(k);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_cmd(input logic we, input logic [AW-1:0] base, input int len, input logic [31:0] seed, output int acc);
    push_exp(we, base, len, seed);
    grant_idx = 0;
    max_out = 0;
    @(posedge clk); #2;
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = base; cmd_len_i = LW'(len); cmd_seed_i = seed;
    @(negedge clk);
    check_val("cmd_rdy", cmd_ready_o, 1);
    acc = cyc;
    @(posedge clk); #2;
    cmd_valid_i = 1'b0;
  endtask

  task automatic run_cmd(input logic we, input logic [AW-1:0] base, input int len, input logic [31:0] seed, output int lat_cyc);
    int acc;
    bit seen;
    send_cmd(we, base, len, seed, acc);
    seen = 1'b0;
    lat_cyc = -1;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
        lat_cyc = cyc - acc;
      end
    end
    if (!seen) check_val("done_timeout", 0, 1);
    check_val("all_req_seen", exp_q.size(), 0);
  endtask

  task automatic check_after_done();
    @(negedge clk);
    check_val("done_pulse", done_o, 0);
    check_val("idle_busy", busy_o, 0);
  endtask

  task automatic check_reset_state();
    check_val("rst_ready", cmd_ready_o, 1);
    check_val("rst_req", obi_req_o, 0);
    check_val("rst_busy", busy_o, 0);
    check_val("rst_done", done_o, 0);
    check_val("rst_err", err_o, 0);
    check_val("rst_mm", mismatch_cnt_o, 0);
    check_val("rst_addr", obi_addr_o, 0);
    check_val("rst_wdata", obi_wdata_o, 0);
    check_val("rst_aid", obi_aid_o, 0);
  endtask

  initial begin
    int l;
    int acc;
    rst = 1'b1;
    cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0; cmd_seed_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state();
    check_val("be_ones", obi_be_o, {(DW/8){1'b1}});
    check_val("rready", obi_rready_o, 1);

    // Write-fill, full grant, 1-cycle memory.
    run_cmd(1'b1, 48'h1000, 4, 32'h10, l);
    check_val("fill_latency", l, 6);
    check_val("fill_err", err_o, 0);
    check_after_done();

    // Read-verify of the fill.
    run_cmd(1'b0, 48'h1000, 4, 32'h10, l);
    check_val("rd_latency", l, 6);
    check_val("rd_mm", mismatch_cnt_o, 0);
    check_val("rd_err", err_o, 0);
    check_after_done();

    // Corrupted response 2.
    corrupt_idx = 2;
    run_cmd(1'b0, 48'h1000, 4, 32'h10, l);
    corrupt_idx = -1;
    check_val("corrupt_mm", mismatch_cnt_o, 1);
    check_after_done();

    // Backpressure: grant low for 3 cycles after grant 2, then verify contents.
    stall_idx = 2;
    run_cmd(1'b1, 48'h2000, 6, 32'h100, l);
    stall_idx = -1;
    check_val("bp_latency", l, 6 + 2 + 3);
    run_cmd(1'b0, 48'h2000, 6, 32'h100, l);
    check_val("bp_rd_mm", mismatch_cnt_o, 0);

    // Outstanding limit with 10-cycle response latency.
    lat = 10;
    run_cmd(1'b1, 48'h3000, 8, 32'hFFFF_FFFE, l);
    check_val("lim_wr_max", max_out, MO);
    run_cmd(1'b0, 48'h3000, 8, 32'hFFFF_FFFE, l);
    check_val("lim_rd_max", max_out, MO);
    check_val("lim_rd_mm", mismatch_cnt_o, 0);
    lat = 1;

    // Zero-length command.
    run_cmd(1'b1, 48'h4000, 0, 32'h0, l);
    check_val("len0_latency", l, 1);
    check_after_done();

    // Error on word 1 stays sticky until the next command.
    err_idx = 1;
    run_cmd(1'b1, 48'h5000, 3, 32'h55, l);
    err_idx = -1;
    check_val("err_set", err_o, 1);
    repeat (4) @(negedge clk);
    check_val("err_sticky", err_o, 1);
    run_cmd(1'b1, 48'h5000, 3, 32'h55, l);
    check_val("err_cleared", err_o, 0);
    check_after_done();

    // Stray response while idle must be ignored.
    stray = 1'b1;
    repeat (3) @(negedge clk);
    check_val("stray_err", err_o, 0);
    check_val("stray_busy", busy_o, 0);
    run_cmd(1'b1, 48'h6000, 2, 32'h66, l);
    check_val("stray_next_lat", l, 4);

    // Reset during DRAIN, then a normal command.
    lat = 10;
    send_cmd(1'b0, 48'h1000, 4, 32'h10, acc);
    repeat (6) @(negedge clk);
    check_val("drain_busy", busy_o, 1);
    check_val("drain_req", obi_req_o, 0);
    rst = 1'b1;
    #1;
    check_reset_state();
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    exp_q.delete();
    lat = 1;
    @(negedge clk);
    check_reset_state();
    run_cmd(1'b1, 48'h7000, 2, 32'h77, l);
    check_val("post_rst_lat", l, 4);
    check_after_done();
    run_cmd(1'b0, 48'h7000, 2, 32'h77, l);
    check_val("post_rst_mm", mismatch_cnt_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
